// File: rtl/galaxian_pkg.sv
// Shared types and screen constants for the alien formation motion engine.
// Latency: none (declarations only); no backpressure.
package galaxian_pkg;

    typedef enum logic [1:0] {
        MODE_EASY   = 2'b00,
        MODE_HARD   = 2'b01,
        MODE_FREEZE = 2'b10
    } alien_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DIVE
    } dive_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/rr_alive_picker.sv
// Round-robin pick of the first living alien strictly after last_idx, with wrap-around.
// Latency: combinational; no backpressure (valid low when nobody is alive).
module rr_alive_picker #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  alive,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] next_idx,
    output logic          valid
);

    always_comb begin
        int          c;
        logic [IW-1:0] ci;
        next_idx = '0;
        valid    = 1'b0;
        c        = 0;
        ci       = '0;
        // k == N lands back on last_idx, so a lone survivor is still picked
        for (int k = 1; k <= N; k++) begin
            c  = (int'(last_idx) + k) % N;
            ci = IW'(c);
            if (!valid && alive[ci]) begin
                valid    = 1'b1;
                next_idx = ci;
            end
        end
    end

endmodule

// File: rtl/alien_formation_motion.sv
// Per-frame formation sway plus round-robin diving alien in hard mode.
// Latency: all outputs registered, updated once per frame edge; no backpressure (freeze mode holds all state).
module alien_formation_motion
    import galaxian_pkg::*;
#(
    parameter int NUM_ALIENS    = 8,
    parameter int X_MIN         = 40,
    parameter int X_MAX         = 200,
    parameter int X_START       = 120,
    parameter int SWAY_STEP     = 1,
    parameter int ALIEN_SPACING = 48,
    parameter int ROW_Y         = 80,
    parameter int DIVE_GAP      = 60,
    parameter int DIVE_STEP     = 4,
    parameter int Y_BOTTOM      = 479,
    parameter int ZIG_PERIOD    = 8,
    parameter int ZIG_DX        = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [1:0]            alien_control,
    input  logic [NUM_ALIENS-1:0] alive,
    output logic [9:0]            formation_x,
    output logic                  dive_active,
    output logic [2:0]            dive_idx,
    output logic [9:0]            dive_x,
    output logic [9:0]            dive_y
);

    dive_state_t state, state_nxt;
    logic        sway_right, sway_right_nxt;
    logic [9:0]  formation_x_nxt;
    logic [9:0]  gap_cnt, gap_cnt_nxt;
    logic [9:0]  zig_cnt, zig_cnt_nxt;
    logic        zig_right, zig_right_nxt;
    logic [2:0]  last_idx, last_idx_nxt;
    logic        dive_active_nxt;
    logic [2:0]  dive_idx_nxt;
    logic [9:0]  dive_x_nxt, dive_y_nxt;

    logic [2:0]  pick_idx;
    logic        pick_vld;
    logic        hard, freeze, exit_bottom;
    logic [10:0] zig_sum;

    rr_alive_picker #(.N(NUM_ALIENS), .IW(3)) u_picker (
        .alive    (alive),
        .last_idx (last_idx),
        .next_idx (pick_idx),
        .valid    (pick_vld)
    );

    assign hard        = (alien_control == MODE_HARD);
    assign freeze      = alien_control[1];
    // 11-bit compare so dive_y + DIVE_STEP cannot wrap past the bottom test
    assign exit_bottom = ({1'b0, dive_y} + 11'(DIVE_STEP)) > 11'(Y_BOTTOM);
    assign zig_sum     = {1'b0, dive_x} + 11'(ZIG_DX);

    always_comb begin
        formation_x_nxt = formation_x;
        sway_right_nxt  = sway_right;
        state_nxt       = state;
        gap_cnt_nxt     = gap_cnt;
        zig_cnt_nxt     = zig_cnt;
        zig_right_nxt   = zig_right;
        last_idx_nxt    = last_idx;
        dive_active_nxt = dive_active;
        dive_idx_nxt    = dive_idx;
        dive_x_nxt      = dive_x;
        dive_y_nxt      = dive_y;

        if (!freeze) begin
            if (sway_right) begin
                if (formation_x == 10'(X_MAX)) begin
                    sway_right_nxt  = 1'b0;
                    formation_x_nxt = formation_x - 10'(SWAY_STEP);
                end else begin
                    formation_x_nxt = formation_x + 10'(SWAY_STEP);
                end
            end else begin
                if (formation_x == 10'(X_MIN)) begin
                    sway_right_nxt  = 1'b1;
                    formation_x_nxt = formation_x + 10'(SWAY_STEP);
                end else begin
                    formation_x_nxt = formation_x - 10'(SWAY_STEP);
                end
            end

            case (state)
                IDLE: begin
                    if (hard && pick_vld) begin
                        state_nxt   = WAIT;
                        gap_cnt_nxt = 10'(DIVE_GAP - 1);
                    end
                end
                WAIT: begin
                    if (!hard || !pick_vld) begin
                        state_nxt = IDLE;
                    end else if (gap_cnt != '0) begin
                        gap_cnt_nxt = gap_cnt - 10'd1;
                    end else begin
                        state_nxt       = DIVE;
                        dive_active_nxt = 1'b1;
                        dive_idx_nxt    = pick_idx;
                        dive_x_nxt      = formation_x + 10'(32'(pick_idx) * ALIEN_SPACING);
                        dive_y_nxt      = 10'(ROW_Y);
                        zig_cnt_nxt     = '0;
                        zig_right_nxt   = 1'b1;
                    end
                end
                DIVE: begin
                    if (!alive[dive_idx] || exit_bottom) begin
                        state_nxt       = IDLE;
                        dive_active_nxt = 1'b0;
                        last_idx_nxt    = dive_idx;
                    end else begin
                        dive_y_nxt = dive_y + 10'(DIVE_STEP);
                        if (zig_right) begin
                            dive_x_nxt = (zig_sum > 11'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : zig_sum[9:0];
                        end else begin
                            dive_x_nxt = (dive_x < 10'(ZIG_DX)) ? 10'd0 : dive_x - 10'(ZIG_DX);
                        end
                        if (zig_cnt == 10'(ZIG_PERIOD - 1)) begin
                            zig_cnt_nxt   = '0;
                            zig_right_nxt = !zig_right;
                        end else begin
                            zig_cnt_nxt = zig_cnt + 10'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            formation_x <= 10'(X_START);
            sway_right  <= 1'b1;
            gap_cnt     <= '0;
            zig_cnt     <= '0;
            zig_right   <= 1'b1;
            last_idx    <= 3'(NUM_ALIENS - 1);
            dive_active <= 1'b0;
            dive_idx    <= '0;
            dive_x      <= '0;
            dive_y      <= '0;
        end else begin
            state       <= state_nxt;
            formation_x <= formation_x_nxt;
            sway_right  <= sway_right_nxt;
            gap_cnt     <= gap_cnt_nxt;
            zig_cnt     <= zig_cnt_nxt;
            zig_right   <= zig_right_nxt;
            last_idx    <= last_idx_nxt;
            dive_active <= dive_active_nxt;
            dive_idx    <= dive_idx_nxt;
            dive_x      <= dive_x_nxt;
            dive_y      <= dive_y_nxt;
        end
    end

endmodule

// File: tb/tb_alien_formation_motion.sv
// Directed bench for alien_formation_motion: vector table plus multi-cycle dive sequences.
module tb_alien_formation_motion;

    localparam int X_MIN   = 40;
    localparam int X_MAX   = 200;
    localparam int X_START = 120;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] alien_control = 2'b00;
    logic [7:0] alive = 8'hFF;
    logic [9:0] formation_x;
    logic       dive_active;
    logic [2:0] dive_idx;
    logic [9:0] dive_x;
    logic [9:0] dive_y;

    int tests = 0;
    int fails = 0;

    alien_formation_motion dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .alien_control (alien_control),
        .alive         (alive),
        .formation_x   (formation_x),
        .dive_active   (dive_active),
        .dive_idx      (dive_idx),
        .dive_x        (dive_x),
        .dive_y        (dive_y)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [7:0] alv;
        int         n;
        int         fx;
        int         act;
        int         idx;
        int         x;
        int         y;
    } vec_t;

    vec_t vt[21];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Closed-form triangle wave of formation_x after n unfrozen edges from reset
    function automatic int fx_model(input int n);
        int span;
        int u;
        span = X_MAX - X_MIN;
        u    = (X_START - X_MIN + n) % (2 * span);
        return X_MIN + ((u <= span) ? u : 2 * span - u);
    endfunction

    task automatic wait_active(input logic v, input int budget, input string nm);
        int k;
        k = 0;
        while (dive_active !== v && k < budget) begin
            step(1);
            k++;
        end
        check(nm, 32'(dive_active), 32'(v));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    initial begin
        int exp_seq[4];
        int hi_cnt;

        //          rst mode   alive  n    fx  act idx  x    y
        vt[0]  = '{1'b1, 2'b00, 8'hFF, 0,   120, 0, 0, 0,   0};
        vt[1]  = '{1'b0, 2'b00, 8'hFF, 80,  200, 0, 0, 0,   0};
        vt[2]  = '{1'b0, 2'b00, 8'hFF, 1,   199, 0, 0, 0,   0};
        vt[3]  = '{1'b0, 2'b00, 8'hFF, 1,   198, 0, 0, 0,   0};
        vt[4]  = '{1'b0, 2'b10, 8'hFF, 5,   198, 0, 0, 0,   0};
        vt[5]  = '{1'b0, 2'b11, 8'hFF, 3,   198, 0, 0, 0,   0};
        vt[6]  = '{1'b0, 2'b00, 8'hFF, 1,   197, 0, 0, 0,   0};
        vt[7]  = '{1'b0, 2'b00, 8'hFF, 157, 40,  0, 0, 0,   0};
        vt[8]  = '{1'b0, 2'b00, 8'hFF, 1,   41,  0, 0, 0,   0};
        vt[9]  = '{1'b1, 2'b01, 8'hFF, 60,  180, 0, 0, 0,   0};
        vt[10] = '{1'b0, 2'b01, 8'hFF, 1,   181, 1, 0, 180, 80};
        vt[11] = '{1'b0, 2'b01, 8'hFF, 8,   189, 1, 0, 196, 112};
        vt[12] = '{1'b0, 2'b01, 8'hFF, 8,   197, 1, 0, 180, 144};
        vt[13] = '{1'b0, 2'b01, 8'hFF, 83,  120, 1, 0, 186, 476};
        vt[14] = '{1'b0, 2'b01, 8'hFF, 1,   119, 0, 0, 186, 476};
        vt[15] = '{1'b0, 2'b01, 8'hFF, 60,  59,  0, 0, 186, 476};
        vt[16] = '{1'b0, 2'b01, 8'hFF, 1,   58,  1, 1, 107, 80};
        vt[17] = '{1'b0, 2'b01, 8'hFF, 10,  48,  1, 1, 119, 120};
        vt[18] = '{1'b1, 2'b01, 8'hFF, 0,   120, 0, 0, 0,   0};
        vt[19] = '{1'b0, 2'b01, 8'hFF, 60,  180, 0, 0, 0,   0};
        vt[20] = '{1'b0, 2'b01, 8'hFF, 1,   181, 1, 0, 180, 80};

        for (int i = 0; i < 21; i++) begin
            alien_control = vt[i].mode;
            alive         = vt[i].alv;
            if (vt[i].rst) do_reset();
            step(vt[i].n);
            check($sformatf("v%0d formation_x", i), 32'(formation_x), 32'(vt[i].fx));
            check($sformatf("v%0d dive_active", i), 32'(dive_active), 32'(vt[i].act));
            check($sformatf("v%0d dive_idx", i),    32'(dive_idx),    32'(vt[i].idx));
            check($sformatf("v%0d dive_x", i),      32'(dive_x),      32'(vt[i].x));
            check($sformatf("v%0d dive_y", i),      32'(dive_y),      32'(vt[i].y));
        end

        // Round-robin over a sparse alive mask
        exp_seq = '{0, 2, 7, 0};
        alien_control = 2'b01;
        alive         = 8'b1000_0101;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            wait_active(1'b1, 200, $sformatf("rr%0d launch", d));
            check($sformatf("rr%0d dive_idx", d), 32'(dive_idx), 32'(exp_seq[d]));
            wait_active(1'b0, 200, $sformatf("rr%0d end", d));
        end

        // Diver killed mid-flight
        alive = 8'hFF;
        do_reset();
        step(61);
        check("kill launch", 32'(dive_active), 32'd1);
        step(30);
        check("kill y200", 32'(dive_y), 32'd200);
        alive = 8'hFE;
        step(1);
        check("kill drop", 32'(dive_active), 32'd0);
        check("kill y hold", 32'(dive_y), 32'd200);
        wait_active(1'b1, 200, "kill relaunch");
        check("kill next idx", 32'(dive_idx), 32'd1);

        // Freeze mid-dive, then easy mode lets the dive finish with no relaunch
        alive = 8'hFF;
        do_reset();
        step(61 + 55);
        check("md y300", 32'(dive_y), 32'd300);
        check("md x", 32'(dive_x), 32'd194);
        alien_control = 2'b10;
        step(5);
        check("frz fx", 32'(formation_x), 32'(fx_model(116)));
        check("frz x", 32'(dive_x), 32'd194);
        check("frz y", 32'(dive_y), 32'd300);
        check("frz act", 32'(dive_active), 32'd1);
        alien_control = 2'b00;
        step(44);
        check("easy y476", 32'(dive_y), 32'd476);
        check("easy x", 32'(dive_x), 32'd186);
        check("easy act", 32'(dive_active), 32'd1);
        check("easy fx", 32'(formation_x), 32'(fx_model(160)));
        step(1);
        check("easy exit", 32'(dive_active), 32'd0);
        hi_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (dive_active !== 1'b0) hi_cnt++;
        end
        check("easy no relaunch", 32'(hi_cnt), 32'd0);
        check("easy sway", 32'(formation_x), 32'(fx_model(261)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
